// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM issuing fetch/decode/execute control strobes to a SPARC-like datapath
module control_sequencer (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IR,
  input  logic        MFC,
  input  logic        COND,
  output logic        IRE,
  output logic        MDRE,
  output logic        MARE,
  output logic        PCE,
  output logic        nPCE,
  output logic        ClrPC,
  output logic        nPCClr,
  output logic        IRClr,
  output logic        nPC_ADD,
  output logic        nPC_ADDSEL,
  output logic        MFA,
  output logic        MOP_SEL,
  output logic        RFE,
  output logic        ALUE,
  output logic        RA_SEL,
  output logic        AOP_SEL,
  output logic        DISP_SEL,
  output logic        BAUX,
  output logic [1:0]  nPC_SEL,
  output logic [1:0]  MAR_SEL,
  output logic [1:0]  MDR_SEL,
  output logic [1:0]  CIN_SEL,
  output logic [1:0]  RC_SEL,
  output logic [1:0]  ALU_SEL,
  output logic [5:0]  OP1,
  output logic        ERR,
  output logic [4:0]  STATE
);
  typedef enum logic [4:0] {
    RST, RST_NPC, FETCH1, FETCH2, FETCH3, DECODE, ALU, BR_TAKEN,
    PC_UPD, NPC_UPD, ANNUL_PC, ANNUL_NPC, HALT
  } state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic bicc, timeout, unused_ir;
  assign unused_ir = ^{IR[28:25], IR[21:0]};
  assign bicc = IR[31:30] == 2'b00 && IR[24:22] == 3'b010;
  assign timeout = state == FETCH2 && !MFC && cnt == 4'd14;
  assign STATE = state;
  // state register; Clr drops the machine into RST at once, abandoning any access
  always_ff @(posedge Clk or negedge Clr)
    if (!Clr) state <= RST;
    else state <= next;
  // wait-cycle counter runs only while in FETCH2; ERR latches a memory timeout
  always_ff @(posedge Clk or negedge Clr)
    if (!Clr) begin
      cnt <= 4'd0;
      ERR <= 1'b0;
    end else begin
      cnt <= state == FETCH2 ? cnt + 4'd1 : 4'd0;
      ERR <= ERR | timeout;
    end
  // next-state selection
  always_comb begin
    next = state;
    case (state)
      RST:       next = RST_NPC;
      RST_NPC:   next = FETCH1;
      FETCH1:    next = FETCH2;
      FETCH2:    next = MFC ? FETCH3 : timeout ? HALT : FETCH2;
      FETCH3:    next = DECODE;
      DECODE:    next = IR[31:30] == 2'b10 ? ALU :
                        bicc && COND ? BR_TAKEN :
                        bicc && IR[29] ? ANNUL_PC : PC_UPD;
      ALU:       next = PC_UPD;
      BR_TAKEN:  next = FETCH1;
      PC_UPD:    next = NPC_UPD;
      NPC_UPD:   next = FETCH1;
      ANNUL_PC:  next = ANNUL_NPC;
      ANNUL_NPC: next = PC_UPD;
      HALT:      next = HALT;
      default:   next = RST;
    endcase
  end
  // outputs decoded from state: idle values first, then each state's deviations
  always_comb begin
    IRE = 1'b1; MDRE = 1'b1; MARE = 1'b1; PCE = 1'b1; nPCE = 1'b1;
    ClrPC = 1'b1; nPCClr = 1'b1; IRClr = 1'b1; RFE = 1'b1;
    nPC_ADD = 1'b0; nPC_ADDSEL = 1'b0; MFA = 1'b0; MOP_SEL = 1'b1;
    ALUE = 1'b0; RA_SEL = 1'b0; AOP_SEL = 1'b0; DISP_SEL = 1'b0; BAUX = 1'b0;
    nPC_SEL = 2'd0; MAR_SEL = 2'd0; MDR_SEL = 2'd0; CIN_SEL = 2'd0;
    RC_SEL = 2'd0; ALU_SEL = 2'd0; OP1 = 6'h00;
    case (state)
      RST: begin
        ClrPC = 1'b0; nPCClr = 1'b0; IRClr = 1'b0;
      end
      RST_NPC, NPC_UPD, ANNUL_NPC: begin
        nPC_ADD = 1'b1; nPCE = 1'b0;
      end
      FETCH1: begin
        MARE = 1'b0; MAR_SEL = 2'd1;
      end
      FETCH2: begin
        MFA = 1'b1; MDRE = 1'b0; OP1 = 6'h08;
      end
      FETCH3: IRE = 1'b0;
      ALU: begin
        RFE = 1'b0; ALUE = 1'b1; CIN_SEL = 2'd2;
      end
      BR_TAKEN: begin
        PCE = 1'b0; nPC_SEL = 2'd2; BAUX = 1'b1; nPCE = 1'b0;
      end
      PC_UPD, ANNUL_PC: PCE = 1'b0;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized instruction streams checked against a per-instruction state-trace model
module tb_control_sequencer;
  logic Clk = 1'b0, Clr = 1'b0, MFC = 1'b0, COND = 1'b0;
  logic [31:0] IR = 32'h0;
  logic IRE, MDRE, MARE, PCE, nPCE, ClrPC, nPCClr, IRClr;
  logic nPC_ADD, nPC_ADDSEL, MFA, MOP_SEL, RFE, ALUE, RA_SEL, AOP_SEL, DISP_SEL, BAUX;
  logic [1:0] nPC_SEL, MAR_SEL, MDR_SEL, CIN_SEL, RC_SEL, ALU_SEL;
  logic [5:0] OP1;
  logic ERR;
  logic [4:0] STATE;
  int n_cmp = 0, n_err = 0;

  control_sequencer dut (
    .Clk(Clk), .Clr(Clr), .IR(IR), .MFC(MFC), .COND(COND),
    .IRE(IRE), .MDRE(MDRE), .MARE(MARE), .PCE(PCE), .nPCE(nPCE),
    .ClrPC(ClrPC), .nPCClr(nPCClr), .IRClr(IRClr),
    .nPC_ADD(nPC_ADD), .nPC_ADDSEL(nPC_ADDSEL), .MFA(MFA), .MOP_SEL(MOP_SEL),
    .RFE(RFE), .ALUE(ALUE), .RA_SEL(RA_SEL), .AOP_SEL(AOP_SEL),
    .DISP_SEL(DISP_SEL), .BAUX(BAUX),
    .nPC_SEL(nPC_SEL), .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL),
    .CIN_SEL(CIN_SEL), .RC_SEL(RC_SEL), .ALU_SEL(ALU_SEL),
    .OP1(OP1), .ERR(ERR), .STATE(STATE)
  );

  always #5 Clk = ~Clk;

  localparam int S_RST = 0, S_RST_NPC = 1, S_FETCH1 = 2, S_FETCH2 = 3, S_FETCH3 = 4,
                 S_DECODE = 5, S_ALU = 6, S_BR = 7, S_PC = 8, S_NPC = 9,
                 S_APC = 10, S_ANPC = 11, S_HALT = 12;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_state(input int st, input bit err);
    chk("state", {27'd0, STATE}, st);
    chk("mfa", {31'd0, MFA}, st == S_FETCH2);
    chk("op1", {26'd0, OP1}, st == S_FETCH2 ? 32'h08 : 32'h0);
    chk("mare", {31'd0, MARE}, st != S_FETCH1);
    chk("ire", {31'd0, IRE}, st != S_FETCH3);
    chk("alue", {31'd0, ALUE}, st == S_ALU);
    chk("rfe", {31'd0, RFE}, st != S_ALU);
    chk("baux", {31'd0, BAUX}, st == S_BR);
    chk("pce", {31'd0, PCE}, !(st == S_BR || st == S_PC || st == S_APC));
    chk("npce", {31'd0, nPCE}, !(st == S_RST_NPC || st == S_BR || st == S_NPC || st == S_ANPC));
    chk("npc_sel", {30'd0, nPC_SEL}, st == S_BR ? 32'd2 : 32'd0);
    chk("err", {31'd0, ERR}, err);
  endtask

  task automatic do_reset;
    Clr = 1'b0;
    MFC = 1'b0;
    #2;
    chk("rst_state", {27'd0, STATE}, S_RST);
    chk("rst_clears", {29'd0, ClrPC, nPCClr, IRClr}, 0);
    chk("rst_err", {31'd0, ERR}, 0);
    chk("rst_mfa", {31'd0, MFA}, 0);
    @(negedge Clk);
    Clr = 1'b1;
    tick;
    chk_state(S_RST_NPC, 1'b0);
    chk("rst_npc_add", {31'd0, nPC_ADD}, 1);
    tick;
  endtask

  // Expected trace built from the instruction class; w = cycles MFC stays low in FETCH2.
  task automatic run_instr(input logic [31:0] ir, input bit cond, input int w);
    int q[$];
    bit m[$];
    int cls, n_alu, n_pc, n_rfe, n_baux;
    bit bicc;
    bicc = (ir >> 30) == 0 && ((ir >> 22) & 7) == 2;
    cls = (ir >> 30) == 2 ? 1 : (bicc && cond) ? 2 : (bicc && ir[29]) ? 3 : 0;
    q.push_back(S_FETCH1); m.push_back(0);
    for (int i = 0; i < w && i < 15; i++) begin q.push_back(S_FETCH2); m.push_back(0); end
    if (w < 15) begin
      q.push_back(S_FETCH2); m.push_back(1);
      q.push_back(S_FETCH3); m.push_back(0);
      q.push_back(S_DECODE); m.push_back(0);
      if (cls == 1) begin q.push_back(S_ALU); m.push_back(0); end
      if (cls == 2) begin q.push_back(S_BR); m.push_back(0); end
      if (cls == 3) begin
        q.push_back(S_APC); m.push_back(0);
        q.push_back(S_ANPC); m.push_back(0);
      end
      if (cls != 2) begin
        q.push_back(S_PC); m.push_back(0);
        q.push_back(S_NPC); m.push_back(0);
      end
    end else begin
      q.push_back(S_HALT); m.push_back(0);
    end
    IR = ir;
    COND = cond;
    n_alu = 0; n_pc = 0; n_rfe = 0; n_baux = 0;
    foreach (q[i]) begin
      MFC = m[i];
      chk_state(q[i], q[i] == S_HALT);
      n_alu += int'(ALUE);
      n_pc += int'(!PCE);
      n_rfe += int'(!RFE);
      n_baux += int'(BAUX);
      if (ALUE && BAUX) chk("alue_baux_excl", 1, 0);
      tick;
    end
    MFC = 1'b0;
    if (w < 15) begin
      chk("alu_cycles", n_alu, cls == 1);
      chk("rfe_cycles", n_rfe, cls == 1);
      chk("baux_cycles", n_baux, cls == 2);
      chk("pce_cycles", n_pc, cls == 3 ? 2 : 1);
      chk("back_to_fetch1", {27'd0, STATE}, S_FETCH1);
    end
  endtask

  initial begin
    logic [31:0] r;
    int k;
    do_reset;
    run_instr(32'h9C044012, 1'b0, 2);
    run_instr(32'h3C800005, 1'b0, 0);
    run_instr(32'h3C800005, 1'b1, 1);
    run_instr(32'h01000000, 1'b0, 0);
    run_instr(32'h1C800005, 1'b0, 3);
    run_instr(32'h9C044012, 1'b1, 14);
    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      k = $urandom_range(0, 3);
      if (k == 0) r[31:30] = 2'b10;
      if (k == 1) begin r[31:30] = 2'b00; r[24:22] = 3'b010; end
      run_instr(r, 1'($urandom_range(0, 1)), $urandom_range(0, 14));
    end
    run_instr(32'h9C044012, 1'b0, 15);
    MFC = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_state(S_HALT, 1'b1);
    end
    do_reset;
    run_instr(32'h01000000, 1'b0, 1);
    IR = 32'h9C044012;
    MFC = 1'b0;
    tick;
    chk("midfetch_mfa_before", {31'd0, MFA}, 1);
    #3;
    Clr = 1'b0;
    #1;
    chk("midfetch_mfa", {31'd0, MFA}, 0);
    chk("midfetch_state", {27'd0, STATE}, S_RST);
    do_reset;
    run_instr(32'h3C800005, 1'b1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
  Clk  in  1  clock; all state changes on rising edge.
  Clr  in  1  asynchronous active-low reset.
  IR  in  32  instruction register from datapath.
  MFC  in  1  memory function complete.
  COND  in  1  branch condition true, from condition tester.
  IRE, MDRE, MARE, PCE, nPCE  out  1 each  register load enables, active-low.
  ClrPC, nPCClr, IRClr  out  1 each  datapath clears, active-low.
  nPC_ADD, nPC_ADDSEL, MFA, MOP_SEL, RFE, ALUE, RA_SEL, AOP_SEL, DISP_SEL, BAUX  out  1 each  datapath controls; RFE is active-low.
  nPC_SEL, MAR_SEL, MDR_SEL, CIN_SEL, RC_SEL, ALU_SEL  out  2 each  datapath mux selects.
  OP1  out  6  memory operation code.
  ERR  out  1  sticky memory-timeout flag.
  STATE  out  5  current state, debug only.
REQ-002 SHALL use one clock domain; reset SHALL be asynchronous and active-low.

Function
REQ-003 SHALL be a Moore FSM; all outputs SHALL be registered or decoded from state only.
REQ-004 SHALL use these states: RST, RST_NPC, FETCH1, FETCH2, FETCH3, DECODE, ALU, BR_TAKEN, PC_UPD, NPC_UPD, ANNUL_PC, ANNUL_NPC, HALT.
REQ-005 Idle output values: all active-low outputs 1; nPC_ADD, MFA, ALUE, BAUX 0; MOP_SEL 1; all selects 0; OP1 0. Each state drives only the deviations listed below.
REQ-006 RST: ClrPC=nPCClr=IRClr=0 for one cycle, then go to RST_NPC.
REQ-007 RST_NPC: nPC_ADD=1, nPCE=0 (nPC<-PC+4), then go to FETCH1.
REQ-008 FETCH1: MARE=0, MAR_SEL=1 (MAR<-PC), then go to FETCH2.
REQ-009 FETCH2: MFA=1, MDRE=0, MDR_SEL=0, OP1=6'h08.
  - Hold FETCH2 until MFC=1, then go to FETCH3.
REQ-010 FETCH2 SHALL count wait cycles in a 4-bit counter, cleared on entry.
  - MFC sampled 1 on the 15th wait cycle SHALL still be accepted.
  - If the counter reaches 15 with MFC=0: set ERR=1 and go to HALT.
REQ-011 FETCH3: IRE=0 (IR<-MDR), then go to DECODE.
REQ-012 DECODE: no outputs asserted. Branch on IR:
  - IR[31:30]=2'b10 -> ALU.
  - IR[31:30]=2'b00 with IR[24:22]=3'b010 (Bicc) -> BR_TAKEN if COND=1.
  - Bicc with COND=0 and annul bit IR[29]=1 -> ANNUL_PC.
  - All other encodings -> PC_UPD (executed as no-op).
REQ-013 ALU: RFE=0, ALUE=1, CIN_SEL=2, RC_SEL=0, RA_SEL=0, AOP_SEL=0, ALU_SEL=0, then go to PC_UPD.
REQ-014 BR_TAKEN: PCE=0 (PC<-nPC), nPC_SEL=2, DISP_SEL=0, BAUX=1, nPCE=0 (nPC<-PC+disp22*4), then go to FETCH1.
REQ-015 PC_UPD: PCE=0 (PC<-nPC), then go to NPC_UPD.
REQ-016 NPC_UPD: nPC_ADD=1, nPCE=0, nPC_ADDSEL=0, then go to FETCH1.
REQ-017 ANNUL_PC and ANNUL_NPC SHALL perform PC_UPD then NPC_UPD actions, then go to PC_UPD, skipping the delay slot.
REQ-018 HALT: all outputs at idle value, held until reset; ERR holds 1.
REQ-019 PC, nPC and MAR SHALL never be loaded in the same state as a memory request except as listed above.
REQ-020 At most one of ALUE and BAUX SHALL be 1 in any cycle.
REQ-021 STATE SHALL encode states 0..12 in REQ-004 order.

Reset
REQ-022 Clr=0 SHALL immediately force state RST, clear the counter, clear ERR, and drive outputs to RST values, regardless of clock.
REQ-023 Clr asserted mid-fetch SHALL abandon the access; MFA SHALL drop to 0 asynchronously.
REQ-024 After Clr deasserts, FETCH1 SHALL be reached on the 2nd rising edge.

Verification
REQ-025 Reset then MFC=1 after 2 wait cycles, IR=32'h9C044012 -> states RST, RST_NPC, FETCH1, FETCH2 (3 cycles), FETCH3, DECODE, ALU, PC_UPD, NPC_UPD, FETCH1; ALUE=1 for exactly one cycle.
REQ-026 IR=32'h3C800005, COND=0 -> ANNUL_PC, ANNUL_NPC, PC_UPD, NPC_UPD; PCE=0 in exactly 2 cycles.
REQ-027 IR=32'h3C800005, COND=1 -> BR_TAKEN with nPC_SEL=2, BAUX=1, PCE=0, nPCE=0, then FETCH1.
REQ-028 MFC held 0 in FETCH2 -> ERR=1 after 15 wait cycles, STATE=12 stays; Clr pulse -> ERR=0, STATE=0.
REQ-029 Clr asserted between clock edges during FETCH2 -> MFA=0 and STATE=0 before the next edge.
REQ-030 IR=32'h01000000 (SETHI/NOP) -> DECODE, PC_UPD, NPC_UPD, with no RFE=0 and no ALUE=1.
